// File: rtl/led_dimmer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_dimmer_ctrl
// Description : Two-button LED brightness controller. Raw up/down buttons are
//               synchronised and debounced, drive a saturating level register,
//               and the level is rendered as a registered PWM waveform.
//               Optional hold-to-repeat is enabled by defining AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module led_dimmer_ctrl #(
    parameter int LEVELS          = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_BITS        = 8,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [1:0]                i_button,
    output logic [$clog2(LEVELS)-1:0] o_level,
    output logic                      o_light,
    output logic [1:0]                o_press
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                LVL_W   = $clog2(LEVELS);
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                PROD_W  = PWM_BITS + LVL_W;
    localparam logic [LVL_W-1:0]  LVL_TOP = LVL_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0]  DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [PROD_W-1:0] DUTY_DIV = PROD_W'(LEVELS - 1);

    // Reject parameter sets the datapath cannot represent.
    generate
        if (LEVELS < 2 || DEBOUNCE_CYCLES < 1 || PWM_BITS < 1 ||
            REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_param_check
            $error("led_dimmer_ctrl: illegal parameter value");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Per-button synchroniser, debouncer and rising-edge detector
    // ------------------------------------------------------------------------
    logic [1:0] w_step;    // one-cycle pulse on each debounced rising edge
`ifdef AUTO_REPEAT_EN
    logic [1:0] w_db;      // debounced level of each button
`endif

    generate
        for (genvar g = 0; g < 2; g++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             db_q;
            logic             db_prev_q;
            logic [CNT_W-1:0] db_cnt_q;
            logic             w_mismatch;

            assign w_mismatch = (sync2_q != db_q);

            // Two-flop synchroniser, then flip db only after DEBOUNCE_CYCLES
            // consecutive mismatching cycles; any agreement restarts the count.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    db_q      <= 1'b0;
                    db_prev_q <= 1'b0;
                    db_cnt_q  <= '0;
                end else begin
                    sync1_q   <= i_button[g];
                    sync2_q   <= sync1_q;
                    db_prev_q <= db_q;
                    if (!w_mismatch) begin
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_MAX) begin
                        db_q     <= sync2_q;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
            end

            // Only a press (rising edge) is an event; releases are silent.
            assign w_step[g] = db_q & ~db_prev_q;
`ifdef AUTO_REPEAT_EN
            assign w_db[g]   = db_q;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Step event source: plain presses, optionally merged with auto-repeats
    // ------------------------------------------------------------------------
    logic [1:0] w_event;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RUN   = 2'd2
    } rpt_state_t;

    rpt_state_t       rpt_state_q;
    rpt_state_t       rpt_state_d;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic [1:0]       w_rpt;
    logic             w_one_held;

    assign w_one_held = w_db[0] ^ w_db[1];

    // Repeat state and cycle counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    // The counter holds the number of cycles since the last step of the
    // single held button; a repeat fires when it reaches the current interval.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        w_rpt       = 2'b00;
        if (!w_one_held) begin
            // Nothing or both held: park and restart on the next single hold.
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
        end else if (rpt_state_q == RPT_IDLE || w_step != 2'b00) begin
            rpt_state_d = RPT_DELAY;
            rpt_cnt_d   = RPT_ONE;
        end else begin
            case (rpt_state_q)
                RPT_DELAY: begin
                    if (rpt_cnt_q == RPT_DLY) begin
                        w_rpt       = w_db;
                        rpt_state_d = RPT_RUN;
                        rpt_cnt_d   = RPT_ONE;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                RPT_RUN: begin
                    if (rpt_cnt_q == RPT_PER) begin
                        w_rpt     = w_db;
                        rpt_cnt_d = RPT_ONE;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    rpt_state_d = RPT_IDLE;
                    rpt_cnt_d   = '0;
                end
            endcase
        end
    end

    assign w_event = w_step | w_rpt;
`else
    assign w_event = w_step;
`endif

    // ------------------------------------------------------------------------
    // Saturating level register and step pulse output
    // ------------------------------------------------------------------------
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [1:0]       press_q;
    logic [1:0]       press_d;

    // Opposing simultaneous events cancel; saturated steps still report.
    always_comb begin
        press_d = w_event;
        if (w_event == 2'b11) begin
            press_d = 2'b00;
        end
        level_d = level_q;
        if (press_d[0] && level_q != LVL_TOP) begin
            level_d = level_q + 1'b1;
        end else if (press_d[1] && level_q != '0) begin
            level_d = level_q - 1'b1;
        end
    end

    // Level and press pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= '0;
            press_q <= 2'b00;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // ------------------------------------------------------------------------
    // PWM renderer
    // ------------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PROD_W-1:0]   w_duty;
    logic                light_q;
    logic                light_d;

    // duty = level * 2^PWM_BITS / (LEVELS-1); the divisor is a constant.
    assign w_duty  = {level_q, {PWM_BITS{1'b0}}} / DUTY_DIV;

    // Full brightness bypasses the compare so the top level never blinks.
    assign light_d = (level_q == LVL_TOP) || ({{LVL_W{1'b0}}, pwm_cnt_q} < w_duty);

    // Free-running PWM counter and registered LED drive.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwm_cnt_q <= '0;
            light_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            light_q   <= light_d;
        end
    end

    assign o_level = level_q;
    assign o_light = light_q;
    assign o_press = press_q;

endmodule
`default_nettype wire

// File: tb/tb_led_dimmer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_dimmer_ctrl
// Description : Self-checking bench for led_dimmer_ctrl. Expected step events
//               are queued when button stimulus is driven and compared against
//               o_press/o_level on the cycle they are due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_dimmer_ctrl;

    localparam int LEVELS = 4;
    localparam int DEB    = 4;
    localparam int PWMB   = 4;
    localparam int RD     = 20;
    localparam int RC     = 8;
    localparam int LAT    = DEB + 3;    // edge of first sample to press pulse

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] level;
    logic       light;
    logic [1:0] press;

    always #5 clk = ~clk;

    led_dimmer_ctrl #(
        .LEVELS          (LEVELS),
        .DEBOUNCE_CYCLES (DEB),
        .PWM_BITS        (PWMB),
        .REPEAT_DELAY    (RD),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_button (btn),
        .o_level  (level),
        .o_light  (light),
        .o_press  (press)
    );

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] level;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   exp_level = 0;

    // Advance one clock, then at the falling edge compare o_press against the
    // scoreboard: a due event must match, otherwise o_press must be idle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (press !== e.press || level !== e.level) begin
                errors++;
                $display("FAIL press_event @%0d: got press=%b level=%0d, expected press=%b level=%0d",
                         cyc, press, level, e.press, e.level);
            end
        end else begin
            checks++;
            if (press !== 2'b00) begin
                errors++;
                $display("FAIL spurious_press @%0d: got press=%b, expected 00", cyc, press);
            end
        end
    endtask

    // Queue one expected step event 'offset' cycles from now.
    task automatic expect_step(input logic [1:0] mask, input int offset);
        if (mask == 2'b01 && exp_level < LEVELS - 1) exp_level++;
        else if (mask == 2'b10 && exp_level > 0) exp_level--;
        sb.push_back('{cyc + offset, mask, 2'(exp_level)});
    endtask

    task automatic press_btn(input logic [1:0] mask, input int hold, input int gap, input bit expect_evt);
        if (expect_evt) expect_step(mask, LAT + 1);
        btn = mask;
        repeat (hold) step();
        btn = 2'b00;
        repeat (gap) step();
    endtask

    task automatic count_light(output int n);
        n = 0;
        repeat (16) begin
            if (light === 1'b1) n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 2'b00;
        repeat (3) step();
        checks++;
        if (level !== 2'd0 || light !== 1'b0 || press !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: got level=%0d light=%b press=%b, expected 0 0 00", level, light, press);
        end
        rst = 1'b0;
        repeat (16) begin
            step();
            checks++;
            if (level !== 2'd0 || light !== 1'b0) begin
                errors++;
                $display("FAIL idle_period @%0d: got level=%0d light=%b, expected 0 0", cyc, level, light);
            end
        end
    endtask

    task automatic test_first_press();
        int n;
        expect_step(2'b01, LAT + 1);
        btn = 2'b01;
        repeat (LAT + 1) step();
        btn = 2'b00;
        step();
        count_light(n);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL pwm_level1: got %0d high cycles, expected 5", n);
        end
        repeat (12) step();
    endtask

    task automatic test_levels();
        int n;
        press_btn(2'b10, 12, 12, 1'b1);
        for (int i = 0; i < 5; i++) press_btn(2'b01, 12, 12, 1'b1);
        count_light(n);
        checks++;
        if (n !== 16 || level !== 2'd3) begin
            errors++;
            $display("FAIL pwm_level3: got %0d high cycles level=%0d, expected 16 level=3", n, level);
        end
        press_btn(2'b10, 12, 12, 1'b1);
        count_light(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL pwm_level2: got %0d high cycles, expected 10", n);
        end
        for (int i = 0; i < 3; i++) press_btn(2'b10, 12, 12, 1'b1);
        count_light(n);
        checks++;
        if (n !== 0 || level !== 2'd0) begin
            errors++;
            $display("FAIL pwm_level0: got %0d high cycles level=%0d, expected 0 level=0", n, level);
        end
    endtask

    task automatic test_glitch_and_both();
        for (int len = 1; len <= 3; len++) press_btn(2'b01, len, 10, 1'b0);
        checks++;
        if (level !== 2'(exp_level)) begin
            errors++;
            $display("FAIL glitch_level: got %0d, expected %0d", level, exp_level);
        end
        press_btn(2'b11, 12, 12, 1'b0);
        checks++;
        if (level !== 2'(exp_level)) begin
            errors++;
            $display("FAIL both_level: got %0d, expected %0d", level, exp_level);
        end
    endtask

    task automatic test_auto_repeat();
`ifdef AUTO_REPEAT_EN
        int offs[4] = '{20, 28, 36, 44};
`endif
        expect_step(2'b01, LAT + 1);
`ifdef AUTO_REPEAT_EN
        // The release is itself debounced, so the +44 repeat still fires.
        foreach (offs[i]) expect_step(2'b01, LAT + 1 + offs[i]);
`endif
        btn = 2'b01;
        repeat (LAT + 1 + 40) step();
        btn = 2'b00;
        repeat (20) step();
        checks++;
`ifdef AUTO_REPEAT_EN
        if (level !== 2'd3) begin
            errors++;
            $display("FAIL repeat_level: got %0d, expected 3", level);
        end
`else
        if (level !== 2'd1) begin
            errors++;
            $display("FAIL repeat_level: got %0d, expected 1", level);
        end
`endif
    endtask

    task automatic test_reset_mid_press();
        while (exp_level > 1) press_btn(2'b10, 12, 12, 1'b1);
        while (exp_level < 1) press_btn(2'b01, 12, 12, 1'b1);
        expect_step(2'b01, LAT + 1);
        btn = 2'b01;
        repeat (LAT + 1) step();
        repeat (3) step();
        rst = 1'b1;
        step();
        checks++;
        if (level !== 2'd0 || light !== 1'b0 || press !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_press: got level=%0d light=%b press=%b, expected 0 0 00", level, light, press);
        end
        rst = 1'b0;
        exp_level = 0;
        expect_step(2'b01, LAT + 1);
        repeat (LAT + 1) step();
        btn = 2'b00;
        repeat (20) step();
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_levels();
        test_glitch_and_both();
        test_auto_repeat();
        test_reset_mid_press();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending events, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
